// File: rtl/decay_interval_timer.sv
// decay_interval_timer: start/stop interval timer measuring muon decay time with window, afterpulse veto and holdoff.
module decay_interval_timer #(
  parameter int          CNT_W          = 32,
  parameter int unsigned WINDOW_CYCLES  = 5_000_000,
  parameter int unsigned MIN_GAP        = 2,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int          DROP_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start_hit,
  input  logic              stop_hit,
  output logic [CNT_W-1:0]  interval,
  output logic              interval_valid,
  input  logic              interval_ready,
  output logic              timeout,
  output logic              busy,
  output logic [DROP_W-1:0] dropped_cnt
);
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP = CNT_W'(MIN_GAP);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF_CYCLES == 0 ? 0 : HOLDOFF_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARMED, REPORT, HOLDOFF} state_t;
  // The counter saturates at the window, so the window alone must fit in CNT_W.
  if ((64'(WINDOW_CYCLES) >> CNT_W) != 0) begin : g_bad_window
    $error("WINDOW_CYCLES does not fit in CNT_W bits");
  end
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt, r_interval, w_interval;
  logic [HW-1:0]     r_hc, w_hc;
  logic [DROP_W-1:0] r_drop, w_drop;
  logic              r_valid, w_valid, r_timeout, w_timeout, r_busy;
  logic              w_drop_inc;
  state_t            w_after;
  assign w_after    = HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
  assign w_drop_inc = start_hit && (r_state == REPORT || r_state == HOLDOFF) && r_drop != '1;
  assign w_drop     = w_drop_inc ? r_drop + 1'b1 : r_drop;
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_hc       = r_hc;
    w_interval = r_interval;
    w_valid    = r_valid;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: if (enable && start_hit) begin
        w_state = ARMED;
        w_cnt   = CNT_W'(1);
      end
      ARMED: if (!enable) w_state = IDLE;
      else if (stop_hit && r_cnt >= GAP) begin
        w_interval = r_cnt;
        w_valid    = 1'b1;
        w_state    = REPORT;
      end else if (r_cnt == WIN) begin
        w_timeout = 1'b1;
        w_state   = w_after;
        w_hc      = '0;
      end else w_cnt = r_cnt + 1'b1;
      REPORT: if (r_valid && interval_ready) begin
        w_valid = 1'b0;
        w_state = w_after;
        w_hc    = '0;
      end
      default: if (r_hc == HLAST) w_state = IDLE;
      else w_hc = r_hc + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hc       <= '0;
      r_interval <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_hc       <= w_hc;
      r_interval <= w_interval;
      r_valid    <= w_valid;
      r_timeout  <= w_timeout;
      r_busy     <= w_state != IDLE;
      r_drop     <= w_drop;
    end
  end
  assign interval       = r_interval;
  assign interval_valid = r_valid;
  assign timeout        = r_timeout;
  assign busy           = r_busy;
  assign dropped_cnt    = r_drop;
endmodule

// File: tb/tb_decay_interval_timer.sv
// tb_decay_interval_timer: directed bench with a time-based reference model checked every cycle.
module tb_decay_interval_timer;
  localparam int WIN  = 100;
  localparam int GAP  = 2;
  localparam int HOLD = 4;
  localparam int DMAX = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        start_hit = 1'b0;
  logic        stop_hit = 1'b0;
  logic        interval_ready = 1'b1;
  logic [31:0] interval;
  logic        interval_valid, timeout, busy;
  logic [1:0]  dropped_cnt;
  int total = 0;
  int bad = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  decay_interval_timer #(
    .CNT_W(32), .WINDOW_CYCLES(WIN), .MIN_GAP(GAP), .HOLDOFF_CYCLES(HOLD), .DROP_W(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start_hit(start_hit), .stop_hit(stop_hit),
    .interval(interval), .interval_valid(interval_valid), .interval_ready(interval_ready),
    .timeout(timeout), .busy(busy), .dropped_cnt(dropped_cnt)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // Reference: tracks the arming edge, pending report and the edge at which holdoff ends.
  int t = 0;
  int m_t0 = 0;
  int m_hold_edge = -1;
  int m_val = 0;
  int m_drop = 0;
  bit m_armed = 0;
  bit m_pend = 0;
  bit m_to = 0;
  always @(posedge clk) begin
    t = t + 1;
    m_to = 0;
    if (rst) begin
      m_armed = 0; m_pend = 0; m_val = 0; m_drop = 0; m_hold_edge = -1;
    end else if (m_armed) begin
      if (!enable) m_armed = 0;
      else if (stop_hit && t - m_t0 >= GAP) begin
        m_pend = 1; m_val = t - m_t0; m_armed = 0;
      end else if (t - m_t0 == WIN) begin
        m_to = 1; m_armed = 0; m_hold_edge = t + HOLD;
      end
    end else if (m_pend) begin
      if (start_hit) m_drop = m_drop == DMAX ? DMAX : m_drop + 1;
      if (interval_ready) begin
        m_pend = 0; m_hold_edge = t + HOLD;
      end
    end else if (t <= m_hold_edge) begin
      if (start_hit) m_drop = m_drop == DMAX ? DMAX : m_drop + 1;
    end else if (enable && start_hit) begin
      m_armed = 1; m_t0 = t;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("m_interval", interval, m_val);
    chk("m_valid", interval_valid, m_pend);
    chk("m_timeout", timeout, m_to);
    chk("m_busy", busy, m_armed || m_pend || t < m_hold_edge);
    chk("m_dropped", dropped_cnt, m_drop);
  end
  task automatic pulse(input bit st, input bit sp);
    start_hit = st;
    stop_hit = sp;
    @(negedge clk);
    start_hit = 1'b0;
    stop_hit = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) pulse(0, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_interval"}, interval, 0);
    chk({nm, "_valid"}, interval_valid, 0);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_dropped"}, dropped_cnt, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk_on = 1;
    rst = 0;
    run(3);
    pulse(1, 0); run(36); pulse(0, 1);
    chk("t1_interval", interval, 37);
    chk("t1_valid", interval_valid, 1);
    run(1);
    chk("t1_valid_drop", interval_valid, 0);
    run(3);
    chk("t1_busy_hold", busy, 1);
    run(1);
    chk("t1_busy_low", busy, 0);
    pulse(1, 0); run(99);
    chk("t2_no_timeout_early", timeout, 0);
    run(1);
    chk("t2_timeout", timeout, 1);
    chk("t2_no_valid", interval_valid, 0);
    run(1);
    chk("t2_timeout_once", timeout, 0);
    run(2);
    chk("t2_busy_hold", busy, 1);
    run(1);
    chk("t2_busy_low", busy, 0);
    pulse(1, 0); pulse(0, 1);
    chk("t3_gap_ignored", interval_valid, 0);
    run(3); pulse(0, 1);
    chk("t3_interval", interval, 5);
    run(1); pulse(1, 0);
    chk("t3_hold_drop", dropped_cnt, 1);
    run(3);
    interval_ready = 0;
    pulse(1, 0); run(19); pulse(0, 1);
    pulse(1, 0); run(1); pulse(1, 0); pulse(1, 0);
    chk("t4_interval_held", interval, 20);
    chk("t4_valid_held", interval_valid, 1);
    chk("t4_dropped_sat", dropped_cnt, 3);
    interval_ready = 1;
    run(1);
    chk("t4_released", interval_valid, 0);
    chk("t4_interval_kept", interval, 20);
    run(4);
    pulse(1, 0); run(29);
    enable = 0;
    run(1);
    enable = 1;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_valid", interval_valid, 0);
    chk("t5_abort_timeout", timeout, 0);
    enable = 0;
    pulse(1, 0);
    chk("t5_disabled_idle", busy, 0);
    enable = 1;
    pulse(1, 1);
    chk("t5_arm_same_stop", busy, 1);
    chk("t5_stop_ignored", interval_valid, 0);
    run(9); pulse(0, 1);
    chk("t5_interval", interval, 10);
    run(5);
    pulse(1, 0); run(10);
    rst = 1; run(1); rst = 0;
    chk_zero("t6_rst_armed");
    interval_ready = 0;
    pulse(1, 0); run(5); pulse(0, 1);
    chk("t6_pre_rst_valid", interval_valid, 1);
    rst = 1; run(1); rst = 0;
    chk_zero("t6_rst_report");
    interval_ready = 1;
    pulse(1, 0); run(99); pulse(0, 1);
    chk("t6_interval_window", interval, 100);
    chk("t6_valid_window", interval_valid, 1);
    chk("t6_no_timeout", timeout, 0);
    run(5);
    chk("t6_idle", busy, 0);
    pulse(1, 0);
    chk("t6_first_idle_arms", busy, 1);
    chk("t6_no_drop", dropped_cnt, 0);
    enable = 0;
    run(2);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
